// File: rtl/rsp_framer.sv
// Purpose : frames one ALU result as FE, opcode, result hi, result lo, [xor checksum]
//           and feeds it byte by byte into the UART transmitter.
// Latency : first byte (START_BYTE) is offered 1 cycle after rsp_valid is captured.
// Backpr. : each byte is held on uart_tx_data with uart_tx_valid high until
//           uart_tx_ready; rsp_valid arriving while a frame is in flight is dropped
//           and flagged on rsp_dropped.
// Ports   : clock/reset_n          - core clock, async active-low reset
//           rsp_valid/opcode/result - response input, taken only while rsp_ready=1
//           rsp_ready/busy          - idle / frame-in-progress indications
//           rsp_dropped             - same-cycle pulse for a response that was ignored
//           uart_tx_data/valid/ready- byte stream towards the transmitter
module rsp_framer #(
  parameter logic [7:0] START_BYTE = 8'hFE,
  parameter bit         CSUM_EN    = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rsp_valid,
  input  logic [2:0]  rsp_opcode,
  input  logic [15:0] rsp_result,
  output logic        rsp_ready,
  output logic        rsp_dropped,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic        busy
);

  // Each SEND_* state means "that byte is currently presented on uart_tx_data".
  typedef enum logic [2:0] {
    IDLE,
    SEND_START,
    SEND_OP,
    SEND_HI,
    SEND_LO,
    SEND_CSUM
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [15:0] res_q;
  logic [7:0]  csum_q;
  logic [7:0]  tx_data_nxt;
  logic        tx_valid_nxt;
  logic        capture;
  logic        xfer;

  assign rsp_ready   = (state == IDLE);
  assign busy        = ~rsp_ready;
  assign rsp_dropped = rsp_valid & ~rsp_ready;
  assign capture     = rsp_valid & rsp_ready;
  assign xfer        = uart_tx_valid & uart_tx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      uart_tx_data  <= 8'h00;
      uart_tx_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      uart_tx_data  <= tx_data_nxt;
      uart_tx_valid <= tx_valid_nxt;
    end
  end

  // Frame contents are frozen at capture so input changes mid-frame are harmless.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= 3'd0;
      res_q  <= 16'h0000;
      csum_q <= 8'h00;
    end else if (capture) begin
      op_q   <= rsp_opcode;
      res_q  <= rsp_result;
      csum_q <= {5'b0, rsp_opcode} ^ rsp_result[15:8] ^ rsp_result[7:0];
    end
  end

  // Next byte is loaded only on a transfer, so data/valid stay stable while stalled.
  always_comb begin
    state_nxt    = state;
    tx_data_nxt  = uart_tx_data;
    tx_valid_nxt = uart_tx_valid;
    case (state)
      IDLE: begin
        if (rsp_valid) begin
          state_nxt    = SEND_START;
          tx_data_nxt  = START_BYTE;
          tx_valid_nxt = 1'b1;
        end
      end
      SEND_START: begin
        if (xfer) begin
          state_nxt   = SEND_OP;
          tx_data_nxt = {5'b0, op_q};
        end
      end
      SEND_OP: begin
        if (xfer) begin
          state_nxt   = SEND_HI;
          tx_data_nxt = res_q[15:8];
        end
      end
      SEND_HI: begin
        if (xfer) begin
          state_nxt   = SEND_LO;
          tx_data_nxt = res_q[7:0];
        end
      end
      SEND_LO: begin
        if (xfer) begin
          if (CSUM_EN) begin
            state_nxt   = SEND_CSUM;
            tx_data_nxt = csum_q;
          end else begin
            state_nxt    = IDLE;
            tx_valid_nxt = 1'b0;
          end
        end
      end
      SEND_CSUM: begin
        if (xfer) begin
          state_nxt    = IDLE;
          tx_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        tx_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rsp_framer.sv
// Purpose : directed checks of rsp_framer with and without the checksum byte.
// Latency : a byte-queue model predicts every output on every cycle.
// Backpr. : uart_tx_ready is driven high, low and 1-of-3 to exercise stalls.
module tb_rsp_framer;

  logic        clock;
  logic        reset_n;
  logic        rsp_valid;
  logic [2:0]  rsp_opcode;
  logic [15:0] rsp_result;
  logic        uart_tx_ready;

  logic        rsp_ready_a, rsp_dropped_a, uart_tx_valid_a, busy_a;
  logic [7:0]  uart_tx_data_a;
  logic        rsp_ready_b, rsp_dropped_b, uart_tx_valid_b, busy_b;
  logic [7:0]  uart_tx_data_b;

  rsp_framer #(.START_BYTE(8'hFE), .CSUM_EN(1'b1)) dut_a (
    .clock        (clock),
    .reset_n      (reset_n),
    .rsp_valid    (rsp_valid),
    .rsp_opcode   (rsp_opcode),
    .rsp_result   (rsp_result),
    .rsp_ready    (rsp_ready_a),
    .rsp_dropped  (rsp_dropped_a),
    .uart_tx_data (uart_tx_data_a),
    .uart_tx_valid(uart_tx_valid_a),
    .uart_tx_ready(uart_tx_ready),
    .busy         (busy_a)
  );

  rsp_framer #(.START_BYTE(8'hFE), .CSUM_EN(1'b0)) dut_b (
    .clock        (clock),
    .reset_n      (reset_n),
    .rsp_valid    (rsp_valid),
    .rsp_opcode   (rsp_opcode),
    .rsp_result   (rsp_result),
    .rsp_ready    (rsp_ready_b),
    .rsp_dropped  (rsp_dropped_b),
    .uart_tx_data (uart_tx_data_b),
    .uart_tx_valid(uart_tx_valid_b),
    .uart_tx_ready(uart_tx_ready),
    .busy         (busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a frame is just a list of bytes still owed to the transmitter.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] seen_a[$];
  logic [7:0] seen_b[$];
  int         stamp_a[$];
  int         cyc = 0;
  int         busy_cnt_a = 0, busy_cnt_b = 0;
  int         drop_cnt_a = 0, drop_cnt_b = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      qa.delete();
      qb.delete();
    end else begin
      if (uart_tx_valid_a && uart_tx_ready) begin
        seen_a.push_back(uart_tx_data_a);
        stamp_a.push_back(cyc);
      end
      if (uart_tx_valid_b && uart_tx_ready) seen_b.push_back(uart_tx_data_b);
      if (busy_a) busy_cnt_a++;
      if (busy_b) busy_cnt_b++;
      if (rsp_dropped_a) drop_cnt_a++;
      if (rsp_dropped_b) drop_cnt_b++;
      if (qa.size() != 0) begin
        if (uart_tx_ready) void'(qa.pop_front());
      end else if (rsp_valid) begin
        qa.push_back(8'hFE);
        qa.push_back({5'b0, rsp_opcode});
        qa.push_back(rsp_result[15:8]);
        qa.push_back(rsp_result[7:0]);
        qa.push_back({5'b0, rsp_opcode} ^ rsp_result[15:8] ^ rsp_result[7:0]);
      end
      if (qb.size() != 0) begin
        if (uart_tx_ready) void'(qb.pop_front());
      end else if (rsp_valid) begin
        qb.push_back(8'hFE);
        qb.push_back({5'b0, rsp_opcode});
        qb.push_back(rsp_result[15:8]);
        qb.push_back(rsp_result[7:0]);
      end
      cyc++;
    end
  end

  always @(negedge clock) begin
    chk("a_valid", 32'(uart_tx_valid_a), 32'(qa.size() != 0));
    chk("a_ready", 32'(rsp_ready_a), 32'(qa.size() == 0));
    chk("a_busy", 32'(busy_a), 32'(qa.size() != 0));
    chk("a_dropped", 32'(rsp_dropped_a), 32'(rsp_valid && qa.size() != 0));
    if (qa.size() != 0) chk("a_data", 32'(uart_tx_data_a), 32'(qa[0]));
    chk("b_valid", 32'(uart_tx_valid_b), 32'(qb.size() != 0));
    chk("b_ready", 32'(rsp_ready_b), 32'(qb.size() == 0));
    chk("b_busy", 32'(busy_b), 32'(qb.size() != 0));
    chk("b_dropped", 32'(rsp_dropped_b), 32'(rsp_valid && qb.size() != 0));
    if (qb.size() != 0) chk("b_data", 32'(uart_tx_data_b), 32'(qb[0]));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] res);
    rsp_opcode = op;
    rsp_result = res;
    rsp_valid  = 1'b1;
    tick();
    rsp_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic chk_seq(input string name, input logic [7:0] got[$], input int base,
                         input logic [7:0] exp[$]);
    chk({name, "_len"}, 32'(got.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < got.size()) chk({name, "_byte"}, 32'(got[base + i]), 32'(exp[i]));
    end
  endtask

  logic [7:0] exp_q[$];
  int         ba, bb, ca, cb, sa;

  initial begin
    reset_n       = 1'b0;
    rsp_valid     = 1'b0;
    rsp_opcode    = 3'd0;
    rsp_result    = 16'h0000;
    uart_tx_ready = 1'b1;
    #3;
    chk("rst_valid", 32'(uart_tx_valid_a), 32'd0);
    chk("rst_data", 32'(uart_tx_data_a), 32'h00);
    chk("rst_ready", 32'(rsp_ready_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_dropped", 32'(rsp_dropped_a), 32'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    tick();

    // Plain frame, transmitter always ready.
    ba = seen_a.size(); bb = seen_b.size(); ca = busy_cnt_a; cb = busy_cnt_b;
    send(3'd3, 16'h1234);
    wait_idle("s1");
    exp_q = {8'hFE, 8'h03, 8'h12, 8'h34, 8'h25};
    chk_seq("s1_a", seen_a, ba, exp_q);
    exp_q = {8'hFE, 8'h03, 8'h12, 8'h34};
    chk_seq("s1_b", seen_b, bb, exp_q);
    chk("s1_busy_a", 32'(busy_cnt_a - ca), 32'd5);
    chk("s1_busy_b", 32'(busy_cnt_b - cb), 32'd4);

    // Same frame, transmitter ready only 1 cycle in 3.
    ba = seen_a.size(); ca = busy_cnt_a;
    send(3'd3, 16'h1234);
    for (int i = 0; i < 300 && (qa.size() != 0 || qb.size() != 0); i++) begin
      uart_tx_ready = (i % 3 == 2);
      tick();
    end
    uart_tx_ready = 1'b1;
    chk("s2_drained", 32'(qa.size() + qb.size()), 32'd0);
    exp_q = {8'hFE, 8'h03, 8'h12, 8'h34, 8'h25};
    chk_seq("s2_a", seen_a, ba, exp_q);
    chk("s2_busy_a", 32'(busy_cnt_a - ca), 32'd15);
    tick();

    // Second response arrives during SEND_HI and must be dropped.
    ba = seen_a.size(); bb = seen_b.size(); ca = drop_cnt_a; cb = drop_cnt_b;
    send(3'd6, 16'hC3A0);
    tick();
    tick();
    send(3'd7, 16'hFFFF);
    wait_idle("s3");
    exp_q = {8'hFE, 8'h06, 8'hC3, 8'hA0, 8'h65};
    chk_seq("s3_a", seen_a, ba, exp_q);
    exp_q = {8'hFE, 8'h06, 8'hC3, 8'hA0};
    chk_seq("s3_b", seen_b, bb, exp_q);
    chk("s3_drop_a", 32'(drop_cnt_a - ca), 32'd1);
    chk("s3_drop_b", 32'(drop_cnt_b - cb), 32'd1);
    tick();

    // Back-to-back frames with the next response in the first ready cycle.
    ba = seen_a.size(); bb = seen_b.size(); sa = stamp_a.size();
    send(3'd3, 16'h1234);
    for (int i = 0; i < 50 && !rsp_ready_a; i++) tick();
    chk("s4_ready_back", 32'(rsp_ready_a), 32'd1);
    send(3'd0, 16'h00FE);
    wait_idle("s4");
    exp_q = {8'hFE, 8'h03, 8'h12, 8'h34, 8'h25, 8'hFE, 8'h00, 8'h00, 8'hFE, 8'hFE};
    chk_seq("s4_a", seen_a, ba, exp_q);
    exp_q = {8'hFE, 8'h03, 8'h12, 8'h34, 8'hFE, 8'h00, 8'h00, 8'hFE};
    chk_seq("s4_b", seen_b, bb, exp_q);
    if (stamp_a.size() >= sa + 6) begin
      chk("s4_no_bubble", 32'(stamp_a[sa + 4] - stamp_a[sa]), 32'd4);
      chk("s4_gap", 32'(stamp_a[sa + 5] - stamp_a[sa + 4]), 32'd2);
    end else begin
      chk("s4_stamps", 32'(stamp_a.size() - sa), 32'd10);
    end
    tick();

    // Checksum-less framer on its own pattern.
    bb = seen_b.size(); cb = busy_cnt_b;
    send(3'd5, 16'hA55A);
    wait_idle("s5");
    exp_q = {8'hFE, 8'h05, 8'hA5, 8'h5A};
    chk_seq("s5_b", seen_b, bb, exp_q);
    chk("s5_busy_b", 32'(busy_cnt_b - cb), 32'd4);
    tick();

    // Reset while SEND_OP is stalled.
    send(3'd2, 16'h0F0F);
    tick();
    uart_tx_ready = 1'b0;
    tick();
    tick();
    chk("s6_stall_valid", 32'(uart_tx_valid_a), 32'd1);
    chk("s6_stall_data", 32'(uart_tx_data_a), 32'h02);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_async_valid_a", 32'(uart_tx_valid_a), 32'd0);
    chk("s6_async_valid_b", 32'(uart_tx_valid_b), 32'd0);
    chk("s6_async_ready", 32'(rsp_ready_a), 32'd1);
    @(posedge clock);
    #3 reset_n = 1'b1;
    uart_tx_ready = 1'b1;
    ba = seen_a.size(); bb = seen_b.size();
    repeat (8) tick();
    chk("s6_silent_a", 32'(seen_a.size() - ba), 32'd0);
    chk("s6_silent_b", 32'(seen_b.size() - bb), 32'd0);
    chk("s6_idle_ready", 32'(rsp_ready_a), 32'd1);
    send(3'd4, 16'h0001);
    wait_idle("s6");
    exp_q = {8'hFE, 8'h04, 8'h00, 8'h01, 8'h05};
    chk_seq("s6_a", seen_a, ba, exp_q);
    exp_q = {8'hFE, 8'h04, 8'h00, 8'h01};
    chk_seq("s6_b", seen_b, bb, exp_q);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
